// File: rtl/fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_if
// Bundle of the requester-side and FIFO-side signals for fifo_write_arbiter.
//
// Valid/ready semantics: a requester raises req[i] and holds req_data slice i
// stable until it sees gnt[i]=1. The word is accepted in that same cycle,
// and the requester drops req[i] or advances its data on the following edge.
// fifo_wr_en/fifo_wr_data are the FIFO write strobe and data, and the
// arbiter never strobes while fifo_full=1.
//
// Signals:
//   req          NUM_REQ             per-requester write request
//   req_data     NUM_REQ*DATA_WIDTH  flattened data, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt          NUM_REQ             one-hot grant (word accepted this cycle)
//   fifo_full    1                   FIFO full flag
//   fifo_wr_en   1                   FIFO write enable
//   fifo_wr_data DATA_WIDTH          FIFO write data
//
// Modports:
//   master : environment side (requesters + FIFO) drives req, req_data, fifo_full
//   slave  : arbiter side drives gnt, fifo_wr_en, fifo_wr_data
// ---------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;

   modport master (
      output req,
      output req_data,
      output fifo_full,
      input  gnt,
      input  fifo_wr_en,
      input  fifo_wr_data
   );

   modport slave (
      input  req,
      input  req_data,
      input  fifo_full,
      output gnt,
      output fifo_wr_en,
      output fifo_wr_data
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters,
// entirely in the FIFO write-clock domain. One requester is granted per
// cycle (zero-cycle req->gnt), nothing is written while the FIFO is full,
// and a granted requester keeps ownership for up to MAX_BURST consecutive
// accepted writes.
//
// Parameters:
//   NUM_REQ    number of requesters (2..16, any value)
//   DATA_WIDTH FIFO data width
//   MAX_BURST  max consecutive accepted writes per ownership (1 = per-word RR)
//
// Ports:
//   clk          write-domain clock, rising edge
//   rst          synchronous active-high reset
//   bus          fifo_write_arbiter_if.slave (req, req_data, fifo_full in;
//                gnt, fifo_wr_en, fifo_wr_data out)
//   grant_cnt    (only with FIFO_ARB_STATS_EN) NUM_REQ*16 saturating
//                per-requester grant counters, requester i at [i*16 +: 16]
//   dbg_state_o  1 while the arbiter is in BURST (lock held)
//
// Optional feature macro: FIFO_ARB_STATS_EN (adds grant_cnt).
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   fifo_write_arbiter_if.slave      bus,
`ifdef FIFO_ARB_STATS_EN
   output logic [NUM_REQ*16-1:0]    grant_cnt,
`endif
   output logic                     dbg_state_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

   logic [PTR_W-1:0]   owner_nxt;     // (owner+1) mod NUM_REQ
   logic [PTR_W-1:0]   search_start;
   logic [PTR_W-1:0]   search_idx;
   logic [PTR_W-1:0]   win_idx;
   logic               win_found;
   logic               hold;          // lock is held and owner still requesting
   logic               grant_any;
   logic [PTR_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] gnt_w;
   logic [DATA_WIDTH-1:0] wr_data_w;

   // Increment modulo NUM_REQ; NUM_REQ need not be a power of two, so the
   // wrap is explicit rather than relying on pointer overflow.
   function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(NUM_REQ - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign owner_nxt = inc_wrap(owner_q);

   // When the lock is released mid-burst, the search begins just past the
   // old owner so the releasing requester does not immediately win again.
   assign search_start = (state_q == BURST) ? owner_nxt : rr_ptr_q;

   // Rotating priority search: first requester at or after search_start.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      search_idx = search_start;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found && bus.req[search_idx]) begin
            win_found = 1'b1;
            win_idx   = search_idx;
         end
         search_idx = inc_wrap(search_idx);
      end
   end

   assign hold = (state_q == BURST) && bus.req[owner_q];

   // Next-state and grant decision.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      grant_any   = 1'b0;
      grant_idx   = owner_q;

      if (hold) begin
         // Owner keeps the lock; a full FIFO just stalls the burst in place.
         if (!bus.fifo_full) begin
            grant_any   = 1'b1;
            grant_idx   = owner_q;
            burst_cnt_d = burst_cnt_q + 1'b1;
            if ((int'(burst_cnt_q) + 1) == MAX_BURST) begin
               state_d  = IDLE;
               rr_ptr_d = owner_nxt;
            end
         end
      end else if (win_found && !bus.fifo_full) begin
         // Fresh arbitration (IDLE, or same-cycle handover on release).
         grant_any   = 1'b1;
         grant_idx   = win_idx;
         owner_d     = win_idx;
         burst_cnt_d = CNT_W'(1);
         if (MAX_BURST == 1) begin
            state_d  = IDLE;
            rr_ptr_d = inc_wrap(win_idx);
         end else begin
            state_d  = BURST;
         end
      end else if (state_q == BURST) begin
         // Owner let go and nobody could be granted: drop the lock.
         state_d  = IDLE;
         rr_ptr_d = owner_nxt;
      end

      // A cycle with rst asserted never writes.
      if (rst) begin
         grant_any = 1'b0;
      end
   end

   // One-hot grant and write-data mux.
   always_comb begin
      gnt_w     = '0;
      wr_data_w = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_any && (grant_idx == PTR_W'(i))) begin
            gnt_w[i]  = 1'b1;
            wr_data_w = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign bus.gnt          = gnt_w;
   assign bus.fifo_wr_en   = |gnt_w;
   assign bus.fifo_wr_data = wr_data_w;
   assign dbg_state_o      = (state_q == BURST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] grant_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_w[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
               grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
            end
         end
      end
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Two arbiters share the same stimulus: a 4-requester / MAX_BURST=4 instance
// and a 3-requester / MAX_BURST=1 instance (wrap-around on a non power of 2).
// Each cycle the driver applies inputs, asks the reference model which
// requester should be granted, and queues the expected {wr_en, gnt, data}.
// A negedge monitor pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

   logic clk;
   logic rst;
   logic dbg4, dbg3;

   fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus4 ();
   fifo_write_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) bus3 ();

`ifdef FIFO_ARB_STATS_EN
   logic [63:0] gc4;
   logic [47:0] gc3;
`endif

   fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut4 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus4),
`ifdef FIFO_ARB_STATS_EN
      .grant_cnt   (gc4),
`endif
      .dbg_state_o (dbg4)
   );

   fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut3 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus3),
`ifdef FIFO_ARB_STATS_EN
      .grant_cnt   (gc3),
`endif
      .dbg_state_o (dbg3)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;
   logic [12:0] exp_q4[$];
   logic [12:0] exp_q3[$];

   logic [7:0] d[4];
   bit         data_fixed = 0;

   // Reference model: who owns the lock, how many words it has written,
   // and where the next fresh search starts.
   typedef struct {
      int busy;
      int owner;
      int used;
      int ptr;
   } model_t;

   model_t m4, m3;
   int     cnt4[4];
   int     cnt3[3];
   bit     stats_valid = 0;

   task automatic model_step(input int n, input int mb, input logic [3:0] r,
                             input logic full, input logic rs,
                             inout model_t m, output int win);
      int start;
      int was_busy;
      win = -1;
      if (rs) begin
         m.busy = 0; m.owner = 0; m.used = 0; m.ptr = 0;
         return;
      end
      if (m.busy != 0 && r[m.owner]) begin
         if (!full) begin
            win = m.owner;
            m.used++;
            if (m.used == mb) begin
               m.busy = 0;
               m.ptr  = (m.owner + 1) % n;
            end
         end
         return;
      end
      was_busy = m.busy;
      start    = (was_busy != 0) ? (m.owner + 1) % n : m.ptr;
      if (!full) begin
         for (int k = 0; k < n; k++) begin
            if (win < 0 && r[(start + k) % n]) win = (start + k) % n;
         end
      end
      if (win >= 0) begin
         m.owner = win;
         m.used  = 1;
         m.busy  = (mb > 1) ? 1 : 0;
         if (mb == 1) m.ptr = (win + 1) % n;
      end else if (was_busy != 0) begin
         m.busy = 0;
         m.ptr  = start;
      end
   endtask

   function automatic logic [12:0] pack_exp(input int w);
      logic [3:0] g;
      logic [7:0] dd;
      g  = '0;
      dd = '0;
      if (w >= 0) begin
         g[w] = 1'b1;
         dd   = d[w];
      end
      return {(w >= 0), g, dd};
   endfunction

`ifdef FIFO_ARB_STATS_EN
   task automatic check_stats();
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (gc4[i*16 +: 16] !== 16'(cnt4[i])) begin
            fails++;
            $display("FAIL grant_cnt4[%0d] t=%0t got=%h exp=%h", i, $time, gc4[i*16 +: 16], 16'(cnt4[i]));
         end
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (gc3[i*16 +: 16] !== 16'(cnt3[i])) begin
            fails++;
            $display("FAIL grant_cnt3[%0d] t=%0t got=%h exp=%h", i, $time, gc3[i*16 +: 16], 16'(cnt3[i]));
         end
      end
   endtask
`endif

   // ---------------- driver ----------------
   task automatic drive_cycle(input logic [3:0] r, input logic full, input logic rs);
      int w4, w3;
      @(posedge clk);
      #1;
`ifdef FIFO_ARB_STATS_EN
      if (stats_valid) check_stats();
`endif
      if (!data_fixed) begin
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      end
      rst            = rs;
      bus4.req       = r;
      bus4.fifo_full = full;
      bus4.req_data  = {d[3], d[2], d[1], d[0]};
      bus3.req       = r[2:0];
      bus3.fifo_full = full;
      bus3.req_data  = {d[2], d[1], d[0]};
      model_step(4, 4, r, full, rs, m4, w4);
      model_step(3, 1, r, full, rs, m3, w3);
      exp_q4.push_back(pack_exp(w4));
      exp_q3.push_back(pack_exp(w3));
      if (rs) begin
         for (int i = 0; i < 4; i++) cnt4[i] = 0;
         for (int i = 0; i < 3; i++) cnt3[i] = 0;
         stats_valid = 1;
      end else begin
         if (w4 >= 0 && cnt4[w4] < 65535) cnt4[w4]++;
         if (w3 >= 0 && cnt3[w3] < 65535) cnt3[w3]++;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [12:0] e, g;
      if (exp_q4.size() > 0) begin
         e = exp_q4.pop_front();
         g = {bus4.fifo_wr_en, bus4.gnt, bus4.fifo_wr_data};
         tests++;
         if (g !== e) begin
            fails++;
            $display("FAIL arb4 t=%0t got{en,gnt,data}=%b_%b_%h exp=%b_%b_%h",
                     $time, g[12], g[11:8], g[7:0], e[12], e[11:8], e[7:0]);
         end
      end
      if (exp_q3.size() > 0) begin
         e = exp_q3.pop_front();
         g = {bus3.fifo_wr_en, 1'b0, bus3.gnt, bus3.fifo_wr_data};
         tests++;
         if (g !== e) begin
            fails++;
            $display("FAIL arb3 t=%0t got{en,gnt,data}=%b_%b_%h exp=%b_%b_%h",
                     $time, g[12], g[11:8], g[7:0], e[12], e[11:8], e[7:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] r;
      rst            = 1'b1;
      bus4.req       = '0;
      bus4.req_data  = '0;
      bus4.fifo_full = 1'b0;
      bus3.req       = '0;
      bus3.req_data  = '0;
      bus3.fifo_full = 1'b0;
      m4 = '{0, 0, 0, 0};
      m3 = '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++) d[i] = '0;

      // Reset with everyone requesting, then fairness rotation.
      repeat (3) drive_cycle(4'b1111, 1'b0, 1'b1);
      repeat (20) drive_cycle(4'b1111, 1'b0, 1'b0);

      // Full stall: requester 2 alone, fixed data.
      drive_cycle(4'b0000, 1'b0, 1'b1);
      data_fixed = 1;
      for (int i = 0; i < 4; i++) d[i] = 8'hA5;
      repeat (2) drive_cycle(4'b0100, 1'b0, 1'b0);
      repeat (5) drive_cycle(4'b0100, 1'b1, 1'b0);
      repeat (4) drive_cycle(4'b0100, 1'b0, 1'b0);
      data_fixed = 0;

      // Early release: requester 1 drops after 2 writes, 3 takes over.
      drive_cycle(4'b0000, 1'b0, 1'b1);
      repeat (2) drive_cycle(4'b0010, 1'b0, 1'b0);
      repeat (6) drive_cycle(4'b1000, 1'b0, 1'b0);

      // Release while full: nobody granted, lock dropped.
      repeat (2) drive_cycle(4'b0001, 1'b0, 1'b0);
      drive_cycle(4'b0100, 1'b1, 1'b0);
      repeat (3) drive_cycle(4'b0101, 1'b0, 1'b0);

      // Wrap-around for both instances.
      drive_cycle(4'b0000, 1'b0, 1'b1);
      repeat (8) drive_cycle(4'b0111, 1'b0, 1'b0);

      // Reset mid-burst of requester 2, then all requesting.
      drive_cycle(4'b0000, 1'b0, 1'b1);
      repeat (2) drive_cycle(4'b0100, 1'b0, 1'b0);
      drive_cycle(4'b0100, 1'b0, 1'b1);
      repeat (6) drive_cycle(4'b1111, 1'b0, 1'b0);

      // Idle with nothing requesting.
      repeat (3) drive_cycle(4'b0000, 1'b0, 1'b0);

      // Randomized traffic: sticky requests so bursts form and break.
      r = 4'b0000;
      repeat (3000) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         end
         drive_cycle(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 299) == 0));
      end

`ifdef FIFO_ARB_STATS_EN
      // Saturation: requester 0 alone long enough to pin its counter.
      drive_cycle(4'b0000, 1'b0, 1'b1);
      repeat (65540) drive_cycle(4'b0001, 1'b0, 1'b0);
      drive_cycle(4'b0000, 1'b0, 1'b0);
      tests++;
      if (cnt4[0] != 65535 || cnt3[0] != 65535) begin
         fails++;
         $display("FAIL sat_model cnt4=%0d cnt3=%0d exp=65535", cnt4[0], cnt3[0]);
      end
`endif

      drive_cycle(4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      tests++;
      if (exp_q4.size() != 0 || exp_q3.size() != 0) begin
         fails++;
         $display("FAIL queue_drain got=%0d/%0d exp=0/0", exp_q4.size(), exp_q3.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
